// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame decode with
// odd parity and inter-edge timeout, publishing the last two bytes on KBBuffer.
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] KBBuffer,
  output logic        NewCode,
  output logic        FrameErr,
  output logic        Busy
);

  localparam int              FW       = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]   FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [13:0]     TO_CYC   = 14'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          fclk_q, fclk_prev_q;
  logic [FW-1:0] flt_cnt_q;
  state_e        state_q;
  logic [7:0]    sr_q;
  logic [2:0]    bitcnt_q;
  logic          par_ok_q;
  logic [13:0]   timer_q;
  logic          fe, timeout;

  // Synchronisers idle high so reset never looks like a falling edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Counts consecutive samples disagreeing with fclk; any agreeing sample restarts it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      fclk_prev_q <= fclk_q;
      if (clk_s2_q == fclk_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        fclk_q    <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  assign fe      = fclk_prev_q & ~fclk_q;
  assign timeout = (state_q != IDLE) && (timer_q == TO_CYC);
  assign Busy    = (state_q != IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      par_ok_q <= 1'b0;
      timer_q  <= '0;
      KBBuffer <= '0;
      NewCode  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      NewCode  <= 1'b0;
      FrameErr <= 1'b0;
      if (timeout) begin
        // Expiry takes priority over a coincident edge, which is dropped.
        state_q  <= IDLE;
        FrameErr <= 1'b1;
        timer_q  <= '0;
        bitcnt_q <= '0;
        sr_q     <= '0;
      end else begin
        if (fe || state_q == IDLE) timer_q <= '0;
        else                       timer_q <= timer_q + 1'b1;
        if (fe) begin
          case (state_q)
            IDLE: begin
              if (!dat_s2_q) begin
                state_q  <= DATA;
                bitcnt_q <= '0;
              end
            end
            DATA: begin
              sr_q     <= {dat_s2_q, sr_q[7:1]};
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == 3'd7) state_q <= PARITY;
            end
            PARITY: begin
              par_ok_q <= ^{sr_q, dat_s2_q};
              state_q  <= STOP;
            end
            STOP: begin
              if (dat_s2_q && par_ok_q) begin
                KBBuffer <= {KBBuffer[7:0], sr_q};
                NewCode  <= 1'b1;
              end else begin
                FrameErr <= 1'b1;
              end
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised PS/2 frame stimulus with a queue-based scoreboard; a forked monitor
// pops the expected event whenever the receiver pulses NewCode or FrameErr.
module tb_ps2_scancode_rx;

  localparam int FL   = 8;
  localparam int TO   = 600;
  localparam int HALF = 40;

  logic        CLK = 1'b0, RESET_N = 1'b0, PS2_CLK = 1'b1, PS2_DATA = 1'b1;
  logic [15:0] KBBuffer;
  logic        NewCode, FrameErr, Busy;

  typedef struct packed {logic err; logic [15:0] kb;} ev_t;
  ev_t         q[$];
  logic [15:0] model_kb = 16'h0000;
  int          vecs = 0, errs = 0;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .KBBuffer(KBBuffer), .NewCode(NewCode), .FrameErr(FrameErr), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One device bit: data set while clock high, host samples on the falling edge.
  task automatic ps2_bit(input logic d, input bit glitch);
    PS2_DATA = d;
    if (glitch) begin
      cyc(10); PS2_CLK = 1'b0; cyc(FL - 2); PS2_CLK = 1'b1; cyc(HALF - 10 - (FL - 2));
    end else begin
      cyc(HALF);
    end
    PS2_CLK = 1'b0; cyc(HALF); PS2_CLK = 1'b1;
  endtask

  // nbits < 11 sends a truncated frame; expect selects whether an event is queued.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit, input int nbits, input bit expect_ev);
    logic [10:0] fr;
    logic        par;
    bit          good;
    par  = bad_par ? ^b : ~^b;
    fr   = {~bad_stop, par, b, 1'b0};
    good = !bad_par && !bad_stop && nbits == 11;
    if (expect_ev) begin
      if (good) model_kb = {model_kb[7:0], b};
      q.push_back({!good, model_kb});
    end
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == glitch_bit);
    PS2_DATA = 1'b1;
    cyc(2 * HALF);
  endtask

  initial begin
    ev_t e;
    fork
      forever begin
        @(negedge CLK);
        if (RESET_N && (NewCode || FrameErr)) begin
          vecs++;
          if (NewCode && FrameErr) begin
            errs++;
            $display("FAIL exclusive: NewCode and FrameErr both high, kb=%h", KBBuffer);
          end else if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_event: nc=%b fe=%b kb=%h, none expected", NewCode, FrameErr, KBBuffer);
          end else begin
            e = q.pop_front();
            if (FrameErr !== e.err || KBBuffer !== e.kb) begin
              errs++;
              $display("FAIL event: got err=%b kb=%h expected err=%b kb=%h", FrameErr, KBBuffer, e.err, e.kb);
            end
          end
        end
      end
    join_none

    cyc(5);
    chk("reset_kb", KBBuffer, 16'h0000);
    chk("reset_flags", {13'd0, NewCode, FrameErr, Busy}, 16'h0000);
    RESET_N = 1'b1;
    cyc(20);

    send_frame(8'h1C, 0, 0, -1, 11, 1);
    chk("kb_1C", KBBuffer, 16'h001C);
    send_frame(8'hF0, 0, 0, -1, 11, 1);
    chk("kb_F0", KBBuffer, 16'h1CF0);
    send_frame(8'h1C, 0, 0, -1, 11, 1);
    chk("kb_F01C", KBBuffer, 16'hF01C);
    send_frame(8'h5A, 1, 0, -1, 11, 1);
    chk("parity_hold", KBBuffer, 16'hF01C);

    // Start + 5 data bits then silence: timeout abort.
    send_frame(8'h33, 0, 0, -1, 6, 1);
    chk("to_busy_before", {15'd0, Busy}, 16'h0001);
    cyc(TO + 50);
    chk("to_busy_after", {15'd0, Busy}, 16'h0000);
    send_frame(8'h5A, 0, 0, -1, 11, 1);
    chk("kb_after_to", {8'h00, KBBuffer[7:0]}, 16'h005A);

    // Short clock glitches: idle, then mid-frame.
    PS2_CLK = 1'b0; cyc(FL - 2); PS2_CLK = 1'b1; cyc(30);
    chk("glitch_idle_busy", {15'd0, Busy}, 16'h0000);
    send_frame(8'hA5, 0, 0, 4, 11, 1);
    chk("glitch_frame", KBBuffer, 16'h5AA5);

    // Falling edge with data high while idle is not a start bit.
    ps2_bit(1'b1, 0); cyc(20);
    chk("no_start_busy", {15'd0, Busy}, 16'h0000);

    send_frame(8'h29, 0, 1, -1, 11, 1);
    chk("stop_hold", KBBuffer, 16'h5AA5);

    send_frame(8'h29, 0, 0, -1, 11, 1);
    send_frame(8'h29, 0, 0, -1, 11, 1);
    chk("repeat", KBBuffer, 16'h2929);

    // Reset mid-frame after 4 data bits.
    send_frame(8'h77, 0, 0, -1, 5, 0);
    chk("mid_busy", {15'd0, Busy}, 16'h0001);
    RESET_N = 1'b0; #2;
    chk("rst_kb", KBBuffer, 16'h0000);
    chk("rst_flags", {13'd0, NewCode, FrameErr, Busy}, 16'h0000);
    model_kb = 16'h0000;
    cyc(3); RESET_N = 1'b1; cyc(10);
    send_frame(8'h16, 0, 0, -1, 11, 1);
    chk("kb_0016", KBBuffer, 16'h0016);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         r;
      b = 8'($urandom);
      r = int'($urandom_range(0, 9));
      send_frame(b, r == 0, r == 1, (r == 2) ? int'($urandom_range(1, 9)) : -1, 11, 1);
      chk("rand_kb", KBBuffer, model_kb);
    end

    cyc(50);
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
